// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, legal
// oversampling ratios, parity encodings and small bit-level helpers.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam logic [5:0] PRESCALE_8  = 6'd8;
   localparam logic [5:0] PRESCALE_16 = 6'd16;
   localparam logic [5:0] PRESCALE_32 = 6'd32;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Anything outside the legal set falls back to the slowest-safe ratio of 8.
   function automatic logic [5:0] eff_prescale(input logic [5:0] raw);
      logic [5:0] p;
      case (raw)
         PRESCALE_16: p = PRESCALE_16;
         PRESCALE_32: p = PRESCALE_32;
         default:     p = PRESCALE_8;
      endcase
      return p;
   endfunction

   function automatic logic expected_parity(input logic data_xor, input logic par_typ);
      return (par_typ == PAR_ODD) ? ~data_xor : data_xor;
   endfunction

   function automatic logic majority3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit timing for the receiver: edge counter within one bit period,
// three mid-bit sample flops and the majority vote over them.
module uart_rx_sampler
   import uart_rx_pkg::*;
(
   input  logic       CLK,
   input  logic       RST,
   input  logic       rx_in,
   input  logic [5:0] prescale,
   input  logic       start,
   input  logic       run,
   output logic       bit_val,
   output logic       bit_end
);

   logic [5:0] edge_cnt_r;
   logic [2:0] smp_r;
   logic [5:0] mid_s;
   logic [5:0] last_s;

   // Sample points and bit boundary derived from the latched ratio.
   always_comb begin
      mid_s   = {1'b0, prescale[5:1]};
      last_s  = prescale - 6'd1;
      bit_end = run && (edge_cnt_r == last_s);
      bit_val = majority3(smp_r);
   end

   // The start-detect cycle itself is edge 0, so the counter resumes at 1.
   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_cnt_r <= 6'd0;
      end else if (start) begin
         edge_cnt_r <= 6'd1;
      end else if (run && (edge_cnt_r != last_s)) begin
         edge_cnt_r <= edge_cnt_r + 6'd1;
      end else begin
         edge_cnt_r <= 6'd0;
      end
   end

   // Capture the line at P/2-1, P/2 and P/2+1 of every bit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         smp_r <= 3'b000;
      end else if (run) begin
         if (edge_cnt_r == (mid_s - 6'd1)) smp_r[0] <= rx_in;
         if (edge_cnt_r == mid_s)          smp_r[1] <= rx_in;
         if (edge_cnt_r == (mid_s + 6'd1)) smp_r[2] <= rx_in;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver top: frame FSM, data shift register, parity/stop checks and
// registered result strobes with the last good word.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  RX_IN,
   input  logic [5:0]            PRESCALE,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   output logic [DATA_WIDTH-1:0] P_DATA,
   output logic                  DATA_VALID,
   output logic                  PAR_ERR,
   output logic                  STP_ERR
);

   localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   rx_state_e             state_r;
   logic [CNT_W-1:0]      bit_cnt_r;
   logic [DATA_WIDTH-1:0] shift_r;
   logic [DATA_WIDTH-1:0] p_data_r;
   logic [5:0]            presc_r;
   logic                  par_en_r;
   logic                  par_typ_r;
   logic                  par_fail_r;
   logic                  dv_r;
   logic                  pe_r;
   logic                  se_r;

   logic start_s;
   logic run_s;
   logic bit_val_s;
   logic bit_end_s;
   logic stp_fail_s;

   // Start detection and per-bit check terms.
   always_comb begin
      start_s    = (state_r == IDLE) && !RX_IN;
      run_s      = (state_r != IDLE);
      stp_fail_s = ~bit_val_s;
   end

   uart_rx_sampler u_rx_sampler (
      .CLK      (CLK),
      .RST      (RST),
      .rx_in    (RX_IN),
      .prescale (presc_r),
      .start    (start_s),
      .run      (run_s),
      .bit_val  (bit_val_s),
      .bit_end  (bit_end_s)
   );

   // Frame FSM with data path and result strobes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r    <= IDLE;
         bit_cnt_r  <= '0;
         shift_r    <= '0;
         p_data_r   <= '0;
         presc_r    <= PRESCALE_8;
         par_en_r   <= 1'b0;
         par_typ_r  <= PAR_EVEN;
         par_fail_r <= 1'b0;
         dv_r       <= 1'b0;
         pe_r       <= 1'b0;
         se_r       <= 1'b0;
      end else begin
         dv_r <= 1'b0;
         pe_r <= 1'b0;
         se_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (!RX_IN) begin
                  state_r    <= START;
                  presc_r    <= eff_prescale(PRESCALE);
                  par_en_r   <= PAR_EN;
                  par_typ_r  <= PAR_TYP;
                  par_fail_r <= 1'b0;
                  bit_cnt_r  <= '0;
               end
            end
            START: begin
               // A high majority means the falling edge was noise.
               if (bit_end_s) begin
                  state_r <= bit_val_s ? IDLE : DATA;
               end
            end
            DATA: begin
               if (bit_end_s) begin
                  shift_r <= {bit_val_s, shift_r[DATA_WIDTH-1:1]};
                  if (bit_cnt_r == LAST_BIT) begin
                     bit_cnt_r <= '0;
                     state_r   <= par_en_r ? PARITY : STOP;
                  end else begin
                     bit_cnt_r <= bit_cnt_r + 1'b1;
                  end
               end
            end
            PARITY: begin
               if (bit_end_s) begin
                  par_fail_r <= (bit_val_s != expected_parity(^shift_r, par_typ_r));
                  state_r    <= STOP;
               end
            end
            STOP: begin
               // Parity failure outranks a bad stop bit; only clean frames update P_DATA.
               if (bit_end_s) begin
                  state_r <= IDLE;
                  if (par_fail_r) begin
                     pe_r <= 1'b1;
                  end else if (stp_fail_s) begin
                     se_r <= 1'b1;
                  end else begin
                     dv_r     <= 1'b1;
                     p_data_r <= shift_r;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
            end
         endcase
      end
   end

   assign P_DATA     = p_data_r;
   assign DATA_VALID = dv_r;
   assign PAR_ERR    = pe_r;
   assign STP_ERR    = se_r;

endmodule
